// File: rtl/axis_apb_master.sv
// Byte-stream command parser that issues one APB3 transfer per frame
// and returns a status/read-data response frame on a second byte stream.
module axis_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [APB_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [APB_DATA_WIDTH-1:0] m_apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                      m_apb_pready,
  input  logic                      m_apb_pslverr
);

  localparam int AB = APB_ADDR_WIDTH / 8;
  localparam int DB = APB_DATA_WIDTH / 8;
  localparam int M1 = (AB > DB + 1) ? AB : DB + 1;
  localparam int MC = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MC + 1);
  localparam int RW = 8 * (DB + 1);

  localparam logic [CW-1:0] ALAST = CW'(AB - 1);
  localparam logic [CW-1:0] DLAST = CW'(DB - 1);
  localparam logic [CW-1:0] RLAST = CW'(DB);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_SETUP, S_ACCESS, S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             tmo_q, tmo_d;
  logic [CW-1:0]             rlast_q, rlast_d;
  logic [RW-1:0]             rbuf_q, rbuf_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rdy_q, rdy_d;

  logic                      s_hs, m_hs;
  logic [7:0]                status;
  logic [APB_ADDR_WIDTH+7:0] ashift;
  logic [APB_DATA_WIDTH+7:0] dshift;

  assign s_hs   = s_axis_tvalid & rdy_q;
  assign m_hs   = m_axis_tvalid & m_axis_tready;
  assign status = m_apb_pslverr ? 8'hE5 : 8'hA5;
  // Bytes arrive LSB first, so shift each new byte in from the top.
  assign ashift = {s_axis_tdata, paddr_q} >> 8;
  assign dshift = {s_axis_tdata, pwdata_q} >> 8;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rlast_d  = rlast_q;
    rbuf_d   = rbuf_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_hs) begin
          cnt_d = '0;
          if (s_axis_tdata == 8'h01 || s_axis_tdata == 8'h02) begin
            pwrite_d = (s_axis_tdata == 8'h01);
            state_d  = S_ADDR;
          end else begin
            rbuf_d  = RW'(8'hEE);
            rlast_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (s_hs) begin
          paddr_d = ashift[APB_ADDR_WIDTH-1:0];
          if (cnt_q == ALAST) begin
            cnt_d   = '0;
            state_d = pwrite_q ? S_DATA : S_SETUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s_hs) begin
          pwdata_d = dshift[APB_DATA_WIDTH-1:0];
          if (cnt_q == DLAST) begin
            cnt_d   = '0;
            state_d = S_SETUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SETUP: begin
        tmo_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rlast_d = pwrite_q ? '0 : RLAST;
        cnt_d   = '0;
        if (m_apb_pready) begin
          rbuf_d  = pwrite_q ? RW'(status) : {m_apb_prdata, status};
          state_d = S_RESP;
        end else if (tmo_q == TLAST) begin
          rbuf_d  = RW'(8'hE7);
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (m_hs) begin
          rbuf_d = rbuf_q >> 8;
          if (cnt_q == rlast_q) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rlast_q  <= '0;
      rbuf_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rlast_q  <= rlast_d;
      rbuf_q   <= rbuf_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdy_q    <= rdy_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = (state_q == S_RESP);
  assign m_axis_tdata  = rbuf_q[7:0];
  assign m_apb_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign m_apb_penable = (state_q == S_ACCESS);
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pwdata  = pwdata_q;

endmodule
